// File: rtl/uart_fifo.sv
// uart_fifo: transmit and receive byte queues between the CPU register file
// and a UART core. The tx side feeds the UART one byte at a time; the rx side
// drains the UART receive holding register into a first-word-fall-through queue.
//
// Handshakes:
//   CPU push : wr_strobe is a one-cycle request; it is accepted only when
//              tx_full=0. A push while full is silently ignored.
//   CPU pop  : rd_strobe is a one-cycle request; it is accepted only when
//              rx_empty=0. rd_data shows the head and moves one cycle later.
//   UART tx  : uart_tx_strobe/uart_tx_data stay stable until uart_tx_busy=1
//              is sampled. The strobe then drops, and the next byte waits
//              for busy to fall again.
//   UART rx  : a byte is taken once per uart_rx_ready assertion. A one-cycle
//              uart_rx_ready_clear answers it, and ready must fall before the
//              next byte is taken.
// tx_state/rx_state expose the FSM encodings for observation.
module uart_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  raw_clk,
   input  logic                  reset,
   input  logic [7:0]            wr_data,
   input  logic                  wr_strobe,
   output logic                  tx_full,
   output logic                  tx_empty,
   output logic [DEPTH_LOG2:0]   tx_count,
   output logic [7:0]            rd_data,
   input  logic                  rd_strobe,
   output logic                  rx_empty,
   output logic [DEPTH_LOG2:0]   rx_count,
   output logic                  rx_overflow,
   input  logic                  overflow_clear,
   output logic [7:0]            uart_tx_data,
   output logic                  uart_tx_strobe,
   input  logic                  uart_tx_busy,
   input  logic [7:0]            uart_rx_data,
   input  logic                  uart_rx_ready,
   output logic                  uart_rx_ready_clear,
   output logic [1:0]            tx_state,
   output logic                  rx_state
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      TX_IDLE   = 2'd0,
      TX_STROBE = 2'd1,
      TX_WAIT   = 2'd2
   } tx_state_t;

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_CLEAR = 1'b1
   } rx_state_t;

   tx_state_t             tx_fsm;
   rx_state_t             rx_fsm;

   logic [7:0]            tx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] tx_wr_ptr;
   logic [DEPTH_LOG2-1:0] tx_rd_ptr;
   logic [DEPTH_LOG2:0]   tx_cnt;

   logic [7:0]            rx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rx_wr_ptr;
   logic [DEPTH_LOG2-1:0] rx_rd_ptr;
   logic [DEPTH_LOG2:0]   rx_cnt;

   logic                  tx_push;
   logic                  tx_pop;
   logic                  rx_take;
   logic                  rx_push;
   logic                  rx_pop;
   logic                  rx_drop;

   // Queue movement decisions, all taken from registered state plus this cycle's requests.
   always_comb begin
      tx_push = wr_strobe && (tx_cnt != FULL_CNT);
      tx_pop  = (tx_fsm == TX_IDLE) && (tx_cnt != '0) && !uart_tx_busy;
      rx_pop  = rd_strobe && (rx_cnt != '0);
      rx_take = (rx_fsm == RX_IDLE) && uart_rx_ready;
      // A pop in the same cycle frees the slot, so a full queue can still accept.
      rx_push = rx_take && ((rx_cnt != FULL_CNT) || rx_pop);
      rx_drop = rx_take && !rx_push;
   end

   // tx storage write; contents need no reset because the pointers and count define validity.
   always_ff @(posedge raw_clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= wr_data;
   end

   // tx pointers and occupancy.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_cnt    <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
            2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   // tx FSM: present the head byte, hold until the UART goes busy, then wait for it to finish.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         tx_fsm         <= TX_IDLE;
         uart_tx_data   <= 8'h00;
         uart_tx_strobe <= 1'b0;
      end else begin
         case (tx_fsm)
            TX_IDLE: begin
               if (tx_pop) begin
                  uart_tx_data   <= tx_mem[tx_rd_ptr];
                  uart_tx_strobe <= 1'b1;
                  tx_fsm         <= TX_STROBE;
               end
            end
            TX_STROBE: begin
               if (uart_tx_busy) begin
                  uart_tx_strobe <= 1'b0;
                  tx_fsm         <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               if (!uart_tx_busy) tx_fsm <= TX_IDLE;
            end
            default: begin
               uart_tx_strobe <= 1'b0;
               tx_fsm         <= TX_IDLE;
            end
         endcase
      end
   end

   // rx storage write.
   always_ff @(posedge raw_clk) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
   end

   // rx pointers and occupancy.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_cnt    <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
            2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
            default: rx_cnt <= rx_cnt;
         endcase
      end
   end

   // rx FSM: answer each ready assertion with one clear pulse and wait for ready to fall.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         rx_fsm              <= RX_IDLE;
         uart_rx_ready_clear <= 1'b0;
      end else begin
         case (rx_fsm)
            RX_IDLE: begin
               if (uart_rx_ready) begin
                  uart_rx_ready_clear <= 1'b1;
                  rx_fsm              <= RX_CLEAR;
               end
            end
            RX_CLEAR: begin
               uart_rx_ready_clear <= 1'b0;
               if (!uart_rx_ready) rx_fsm <= RX_IDLE;
            end
            default: begin
               uart_rx_ready_clear <= 1'b0;
               rx_fsm              <= RX_IDLE;
            end
         endcase
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge raw_clk) begin
      if (reset)               rx_overflow <= 1'b0;
      else if (rx_drop)        rx_overflow <= 1'b1;
      else if (overflow_clear) rx_overflow <= 1'b0;
   end

   // Status views of registered state only.
   assign tx_count = tx_cnt;
   assign tx_full  = (tx_cnt == FULL_CNT);
   assign tx_empty = (tx_cnt == '0) && (tx_fsm == TX_IDLE);
   assign rx_count = rx_cnt;
   assign rx_empty = (rx_cnt == '0);
   assign rd_data  = (rx_cnt == '0) ? 8'h00 : rx_mem[rx_rd_ptr];
   assign tx_state = tx_fsm;
   assign rx_state = rx_fsm;

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed bench for uart_fifo with a small UART transmitter model.
module tb_uart_fifo;

   logic       raw_clk;
   logic       reset;
   logic [7:0] wr_data;
   logic       wr_strobe;
   logic       tx_full;
   logic       tx_empty;
   logic [4:0] tx_count;
   logic [7:0] rd_data;
   logic       rd_strobe;
   logic       rx_empty;
   logic [4:0] rx_count;
   logic       rx_overflow;
   logic       overflow_clear;
   logic [7:0] uart_tx_data;
   logic       uart_tx_strobe;
   logic       uart_tx_busy;
   logic [7:0] uart_rx_data;
   logic       uart_rx_ready;
   logic       uart_rx_ready_clear;
   logic [1:0] tx_state;
   logic       rx_state;

   // UART model controls
   logic       model_en;
   logic       model_busy;
   logic       force_busy;
   int         dly;
   int         bcnt;
   int         rises;
   int         viol;
   logic       prev_busy;
   logic       prev_strobe;
   logic [7:0] cap_q[$];

   // scoreboard
   logic [7:0] exp_q[$];
   int         n_cmp;
   int         n_err;

   assign uart_tx_busy = model_en ? model_busy : force_busy;

   uart_fifo #(.DEPTH_LOG2(4)) dut (
      .raw_clk             (raw_clk),
      .reset               (reset),
      .wr_data             (wr_data),
      .wr_strobe           (wr_strobe),
      .tx_full             (tx_full),
      .tx_empty            (tx_empty),
      .tx_count            (tx_count),
      .rd_data             (rd_data),
      .rd_strobe           (rd_strobe),
      .rx_empty            (rx_empty),
      .rx_count            (rx_count),
      .rx_overflow         (rx_overflow),
      .overflow_clear      (overflow_clear),
      .uart_tx_data        (uart_tx_data),
      .uart_tx_strobe      (uart_tx_strobe),
      .uart_tx_busy        (uart_tx_busy),
      .uart_rx_data        (uart_rx_data),
      .uart_rx_ready       (uart_rx_ready),
      .uart_rx_ready_clear (uart_rx_ready_clear),
      .tx_state            (tx_state),
      .rx_state            (rx_state)
   );

   // clock / reset block
   initial raw_clk = 1'b0;
   always #5 raw_clk = ~raw_clk;

   // UART transmitter model: busy rises 2 cycles after a strobe and lasts 20 cycles.
   always @(negedge raw_clk) begin
      if (!model_en) begin
         dly         = 0;
         bcnt        = 0;
         model_busy  = 1'b0;
         rises       = 0;
         viol        = 0;
         prev_busy   = 1'b0;
         prev_strobe = 1'b0;
         cap_q.delete();
      end else begin
         if (prev_busy && uart_tx_strobe) viol++;
         if (uart_tx_strobe && !prev_strobe) rises++;
         prev_strobe = uart_tx_strobe;
         if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) model_busy = 1'b0;
         end else if (uart_tx_strobe && !model_busy) begin
            dly++;
            if (dly == 2) begin
               model_busy = 1'b1;
               bcnt       = 20;
               dly        = 0;
               cap_q.push_back(uart_tx_data);
            end
         end
         prev_busy = model_busy;
      end
   end

   task automatic step();
      @(negedge raw_clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_tx(input logic [7:0] b);
      wr_data   = b;
      wr_strobe = 1'b1;
      step();
      wr_strobe = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] b, input logic pop);
      uart_rx_data  = b;
      uart_rx_ready = 1'b1;
      rd_strobe     = pop;
      step();
      rd_strobe     = 1'b0;
      uart_rx_ready = 1'b0;
      step();
   endtask

   // Pop the whole rx queue, comparing each head against exp_q.
   task automatic drain_rx(input string tag);
      int k;
      k = 0;
      while (exp_q.size() > 0) begin
         check($sformatf("%s_%0d", tag, k), rd_data, exp_q.pop_front());
         rd_strobe = 1'b1;
         step();
         rd_strobe = 1'b0;
         k++;
      end
      check({tag, "_empty"}, rx_empty, 1);
   endtask

   // Wait for the tx side to finish n bytes, then compare against exp_q.
   task automatic wait_tx(input string tag, input int n);
      int i;
      i = 0;
      while (i < 1000 && !(cap_q.size() == n && tx_empty)) begin
         step();
         i++;
      end
      check({tag, "_done"}, (cap_q.size() == n && tx_empty), 1);
      check({tag, "_rises"}, rises, n);
      check({tag, "_viol"}, viol, 0);
      for (int j = 0; j < n; j++) begin
         if (j < cap_q.size()) check($sformatf("%s_byte%0d", tag, j), cap_q[j], exp_q[j]);
         else check($sformatf("%s_byte%0d_missing", tag, j), 0, 1);
      end
      exp_q.delete();
   endtask

   // directed stimulus
   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      wr_data = 8'h00; wr_strobe = 1'b0; rd_strobe = 1'b0; overflow_clear = 1'b0;
      uart_rx_data = 8'h00; uart_rx_ready = 1'b0;
      model_en = 1'b0; force_busy = 1'b0;
      step(); step(); step();
      reset = 1'b0;
      step();

      // reset state
      check("rst_tx_full", tx_full, 0);
      check("rst_tx_empty", tx_empty, 1);
      check("rst_tx_count", tx_count, 0);
      check("rst_rx_empty", rx_empty, 1);
      check("rst_rx_count", rx_count, 0);
      check("rst_overflow", rx_overflow, 0);
      check("rst_strobe", uart_tx_strobe, 0);
      check("rst_tx_data", uart_tx_data, 0);
      check("rst_clear", uart_rx_ready_clear, 0);
      check("rst_rd_data", rd_data, 0);

      // three back-to-back pushes transmitted through the UART model
      model_en = 1'b1;
      push_tx(8'h41); push_tx(8'h42); push_tx(8'h43);
      exp_q = '{8'h41, 8'h42, 8'h43};
      wait_tx("t1", 3);

      // 17 pushes while busy: 16 stored, the 17th lost, then drain in order
      force_busy = 1'b1;
      model_en   = 1'b0;
      step();
      for (int i = 0; i < 17; i++) push_tx(8'(i));
      step();
      check("t2_count", tx_count, 16);
      check("t2_full", tx_full, 1);
      check("t2_state_idle", tx_state, 0);
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
      model_en = 1'b1;
      wait_tx("t2", 16);
      check("t2_count_end", tx_count, 0);

      // single received byte, ready held 3 cycles after the clear pulse
      begin
         int pulses;
         pulses = 0;
         uart_rx_data  = 8'h5A;
         uart_rx_ready = 1'b1;
         step();
         check("t3_clear_first", uart_rx_ready_clear, 1);
         check("t3_count", rx_count, 1);
         check("t3_rd_data", rd_data, 8'h5A);
         pulses += int'(uart_rx_ready_clear);
         for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(uart_rx_ready_clear);
         end
         uart_rx_ready = 1'b0;
         for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(uart_rx_ready_clear);
         end
         check("t3_pulses", pulses, 1);
         check("t3_count_hold", rx_count, 1);
         check("t3_rx_idle", rx_state, 0);
         rd_strobe = 1'b1;
         step();
         rd_strobe = 1'b0;
         check("t3_empty", rx_empty, 1);
         check("t3_rd_zero", rd_data, 0);
      end

      // rx full, 17th byte dropped
      for (int i = 0; i < 16; i++) rx_byte(8'h80 + 8'(i), 1'b0);
      check("t4a_count16", rx_count, 16);
      check("t4a_ovf_before", rx_overflow, 0);
      rx_byte(8'hEE, 1'b0);
      check("t4a_ovf", rx_overflow, 1);
      check("t4a_count_after", rx_count, 16);
      for (int i = 0; i < 16; i++) exp_q.push_back(8'h80 + 8'(i));
      drain_rx("t4a");
      overflow_clear = 1'b1;
      step();
      overflow_clear = 1'b0;
      check("t4a_ovf_cleared", rx_overflow, 0);

      // rx full, 17th byte coincides with a pop
      for (int i = 0; i < 16; i++) rx_byte(8'h90 + 8'(i), 1'b0);
      rx_byte(8'hEE, 1'b1);
      check("t4b_ovf", rx_overflow, 0);
      check("t4b_count", rx_count, 16);
      for (int i = 1; i < 16; i++) exp_q.push_back(8'h90 + 8'(i));
      exp_q.push_back(8'hEE);
      drain_rx("t4b");

      // overflow_clear together with a drop: set wins; later clear alone clears
      for (int i = 0; i < 16; i++) rx_byte(8'hA0 + 8'(i), 1'b0);
      uart_rx_data   = 8'hEE;
      uart_rx_ready  = 1'b1;
      overflow_clear = 1'b1;
      step();
      overflow_clear = 1'b0;
      uart_rx_ready  = 1'b0;
      check("t5_set_wins", rx_overflow, 1);
      step();
      check("t5_still_set", rx_overflow, 1);
      overflow_clear = 1'b1;
      step();
      overflow_clear = 1'b0;
      check("t5_cleared", rx_overflow, 0);

      // reset while in TX_STROBE with 5 bytes still queued
      force_busy = 1'b1;
      model_en   = 1'b0;
      step();
      for (int i = 0; i < 6; i++) push_tx(8'hC0 + 8'(i));
      force_busy = 1'b0;
      step();
      check("t6_pre_state", tx_state, 1);
      check("t6_pre_strobe", uart_tx_strobe, 1);
      check("t6_pre_count", tx_count, 5);
      check("t6_pre_data", uart_tx_data, 8'hC0);
      reset = 1'b1;
      step();
      check("t6_strobe", uart_tx_strobe, 0);
      check("t6_count", tx_count, 0);
      check("t6_empty", tx_empty, 1);
      check("t6_state", tx_state, 0);
      check("t6_tx_data", uart_tx_data, 0);
      check("t6_rx_count", rx_count, 0);
      reset = 1'b0;
      step();
      check("t6_after_strobe", uart_tx_strobe, 0);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- Buffered stage between the peripheral register file and the UART core. It queues bytes the CPU writes for transmit and feeds them to the UART one at a time over the UART's strobe/busy handshake.
- It drains received bytes from the UART's ready/clear handshake into a receive queue that the CPU pops.
- This lets software burst up to 2^DEPTH_LOG2 bytes without polling busy per byte.

Parameters:
- DEPTH_LOG2, 4, log2 of the entry count of each FIFO (tx and rx each hold 16 bytes at default).

Ports:
- raw_clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_data  in  8  byte to enqueue for transmit.
- wr_strobe  in  1  one-cycle push request into the tx FIFO.
- tx_full  out  1  tx FIFO holds 2^DEPTH_LOG2 entries.
- tx_empty  out  1  tx FIFO empty and the tx FSM is in TX_IDLE.
- tx_count  out  DEPTH_LOG2+1  tx FIFO occupancy.
- rd_data  out  8  head of the rx FIFO (first-word-fall-through); 0 when empty.
- rd_strobe  in  1  one-cycle pop request from the rx FIFO.
- rx_empty  out  1  rx FIFO empty.
- rx_count  out  DEPTH_LOG2+1  rx FIFO occupancy.
- rx_overflow  out  1  sticky flag: a received byte was dropped.
- overflow_clear  in  1  clears rx_overflow.
- uart_tx_data  out  8  byte presented to the UART.
- uart_tx_strobe  out  1  transmit request to the UART.
- uart_tx_busy  in  1  UART transmitter busy.
- uart_rx_data  in  8  byte received by the UART.
- uart_rx_ready  in  1  UART holds a received byte.
- uart_rx_ready_clear  out  1  acknowledge pulse to the UART.

Behaviour:
- Reset:
  - Both FIFOs empty, with pointers and counts 0.
  - tx_full=0, tx_empty=1, rx_empty=1, rx_overflow=0.
  - uart_tx_strobe=0, uart_tx_data=0, uart_rx_ready_clear=0.
  - Both FSMs return to their IDLE state.
  - Reset mid-transfer abandons the byte: the strobe drops the next cycle and queued data is discarded.
- FIFOs:
  - Circular buffers, with DEPTH_LOG2-bit pointers that wrap naturally and a (DEPTH_LOG2+1)-bit count.
  - Full when count == 2^DEPTH_LOG2.
- tx push:
  - wr_strobe=1 and not full: wr_data is stored at the write pointer and count+1.
  - wr_strobe while full is ignored; data is lost and no flag is raised, because software must check tx_full.
- tx FSM:
  - TX_IDLE: if the FIFO is not empty and uart_tx_busy=0, latch the head into uart_tx_data, pop (count-1), set uart_tx_strobe=1 and go to TX_STROBE.
  - TX_STROBE: hold the strobe and data until uart_tx_busy=1 is sampled, then clear the strobe and go to TX_WAIT.
  - TX_WAIT: when uart_tx_busy=0, go to TX_IDLE.
  - Minimum spacing between strobes is therefore the busy period plus 2 cycles.
  - A push and a pop in the same cycle leave the count unchanged and both take effect.
- rx FSM:
  - RX_IDLE: if uart_rx_ready=1, then:
    - if rx is not full, or rd_strobe pops in this same cycle, push uart_rx_data;
    - otherwise drop the byte and set rx_overflow=1.
  - In both cases assert uart_rx_ready_clear=1 for exactly one cycle and go to RX_CLEAR.
  - RX_CLEAR: wait until uart_rx_ready=0, then go to RX_IDLE. This prevents a double capture of the same byte.
- rx pop:
  - rd_strobe=1 and not empty: advance the read pointer and count-1. rd_data updates to the new head the next cycle.
  - rd_strobe while empty is ignored.
- rx_overflow:
  - Set by a drop and cleared by overflow_clear.
  - If both occur in the same cycle, set wins.
- Status outputs are registered-consistent: they reflect the state after the most recent edge, with no combinational path from inputs to outputs.

Test Plan:
- Reset, then push 0x41,0x42,0x43 on consecutive cycles with the UART model asserting busy 2 cycles after the strobe for 20 cycles -> uart_tx_data sequence 0x41,0x42,0x43; strobe is never high while busy is low after being acknowledged; tx_empty returns to 1.
- Push 17 bytes 0x00..0x10 while uart_tx_busy is held at 1 -> tx_count=16, tx_full=1, byte 0x10 is dropped. Release busy -> exactly 0x00..0x0F are transmitted in order; the pointer wrap is exercised.
- UART model presents 0x5A with rx_ready=1 and drops ready 3 cycles after the clear pulse -> one clear pulse of one cycle, rx_count=1, rd_data=0x5A. One rd_strobe -> rx_empty=1.
- Fill rx with 16 bytes, then deliver a 17th (0xEE) -> rx_overflow=1 and 0xEE absent. Same scenario with rd_strobe coincident with the 17th ready -> no overflow, rx_count stays 16, 0xEE is the last entry.
- overflow_clear pulses in the same cycle as a new drop -> rx_overflow stays 1. A later overflow_clear alone -> 0.
- Assert reset while in TX_STROBE with 5 bytes queued -> next cycle uart_tx_strobe=0, tx_count=0, tx_empty=1, FSM is in TX_IDLE.
